// File: rtl/wb_addr_decoder.sv
// Wishbone (pipelined) 1-to-NSLAVES address decoder and response router with bus-error and watchdog.
// Optional faulting-address capture is enabled by defining WBDEC_ERR_CAPTURE_EN.
module wb_addr_decoder #(
  parameter int NSLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [AW-1:0]         i_wb_addr,
  input  logic [DW-1:0]         i_wb_data,
  input  logic [DW/8-1:0]       i_wb_sel,
  output logic                  o_wb_stall,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [DW-1:0]         o_wb_data,
  output logic [NSLAVES-1:0]    o_s_cyc,
  output logic [NSLAVES-1:0]    o_s_stb,
  output logic                  o_s_we,
  output logic [AW-1:0]         o_s_addr,
  output logic [DW-1:0]         o_s_data,
  output logic [DW/8-1:0]       o_s_sel,
`ifdef WBDEC_ERR_CAPTURE_EN
  output logic [AW-1:0]         o_err_addr,
  output logic                  o_err_valid,
  input  logic                  i_err_clr,
`endif
  input  logic [NSLAVES*DW-1:0] i_s_data,
  input  logic [NSLAVES-1:0]    i_s_ack,
  input  logic [NSLAVES-1:0]    i_s_stall,
  input  logic [NSLAVES-1:0]    i_s_err
);

  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  // state | meaning
  // IDLE  | decoding, forwarding strobe to the winning slave
  // BUSY  | one transaction outstanding at slave sel_q, watchdog running
  // ERR   | unmapped access, o_wb_err pulsing
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state;
  logic [SW-1:0] sel_q;
  logic [15:0]   cnt;
  logic          hit;
  logic [SW-1:0] win;
  logic          accept;
  logic          timeout_hit;
  logic          err_set;

  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
        hit = 1'b1;
        win = SW'(i);
      end
    end
  end

  always_comb begin
    o_s_cyc    = '0;
    o_s_stb    = '0;
    o_wb_stall = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          o_s_cyc[win] = i_wb_cyc;
          o_s_stb[win] = i_wb_cyc & i_wb_stb;
          o_wb_stall   = i_s_stall[win];
        end
      end
      BUSY: begin
        o_s_cyc[sel_q] = i_wb_cyc;
        o_wb_stall     = 1'b1;
      end
      default: o_wb_stall = 1'b1;
    endcase
  end

  assign accept      = (state == IDLE) & i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));
  assign err_set     = (accept & ~hit)
                     | ((state == BUSY) & i_wb_cyc
                        & (i_s_err[sel_q] | (~i_s_ack[sel_q] & timeout_hit)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              sel_q <= win;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              o_wb_err <= 1'b1;
              state    <= ERR;
            end
          end
        end
        BUSY: begin
          // Master abort beats any response; error beats a coincident ack.
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else if (i_s_err[sel_q]) begin
            o_wb_err <= 1'b1;
            state    <= IDLE;
          end else if (i_s_ack[sel_q]) begin
            o_wb_ack  <= 1'b1;
            o_wb_data <= i_s_data[sel_q*DW +: DW];
            state     <= IDLE;
          end else if (timeout_hit) begin
            o_wb_err <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WBDEC_ERR_CAPTURE_EN
  logic [AW-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      o_err_addr  <= '0;
      o_err_valid <= 1'b0;
    end else begin
      if (accept)
        addr_q <= i_wb_addr;
      if (err_set && (!o_err_valid || i_err_clr)) begin
        o_err_addr  <= (state == IDLE) ? i_wb_addr : addr_q;
        o_err_valid <= 1'b1;
      end else if (i_err_clr) begin
        o_err_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_err_set;
  assign unused_err_set = err_set;
`endif

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Directed self-checking bench for wb_addr_decoder (4 slaves, TIMEOUT=8).
// Define WBDEC_ERR_CAPTURE_EN for the error-capture variant as well.
module tb_wb_addr_decoder;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [NS*AW-1:0] BASE = {32'hd0000000, 32'hc0000000, 32'hb0008000, 32'hb0000000};
  localparam logic [NS*AW-1:0] MASK = {32'hffffffff, 32'hfffff000, 32'hffff8000, 32'hffff8000};

  logic clk = 1'b0;
  logic reset;
  logic cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] sel;
  logic stall, ack, err;
  logic [DW-1:0] rdata;
  logic [NS-1:0] s_cyc, s_stb;
  logic s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_sel;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0] s_ack, s_stall, s_err;
`ifdef WBDEC_ERR_CAPTURE_EN
  logic [AW-1:0] err_addr;
  logic err_valid;
  logic err_clr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_addr_decoder #(
    .NSLAVES(NS), .AW(AW), .DW(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr),
    .o_s_data(s_wdata), .o_s_sel(s_sel),
`ifdef WBDEC_ERR_CAPTURE_EN
    .o_err_addr(err_addr), .o_err_valid(err_valid), .i_err_clr(err_clr),
`endif
    .i_s_data(s_data), .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_err(s_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive just after the active edge; sample at the following falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cyc = 0; stb = 0; we = 0; addr = '0; wdata = '0; sel = '0;
    s_ack = '0; s_stall = '0; s_err = '0;
    s_data = {32'h33333333, 32'h22222222, 32'hcafef00d, 32'h00000000};
`ifdef WBDEC_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    next_cycle(); next_cycle();
    reset = 1'b0;
    sample();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_data", rdata, 0);
    check_eq("rst_scyc", s_cyc, 0);
    check_eq("rst_sstb", s_stb, 0);

    // Read S0
    next_cycle();
    cyc = 1; stb = 1; we = 0; addr = 32'hb0000010;
    sample();
    check_eq("rd_sstb", s_stb, 4'b0001);
    check_eq("rd_scyc", s_cyc, 4'b0001);
    check_eq("rd_stall", stall, 0);
    check_eq("rd_saddr", s_addr, 32'hb0000010);
    next_cycle();
    stb = 0; s_ack = 4'b0001; s_data[31:0] = 32'hdeadbeef;
    sample();
    check_eq("rd_busy_sstb", s_stb, 0);
    check_eq("rd_busy_scyc", s_cyc, 4'b0001);
    check_eq("rd_busy_stall", stall, 1);
    check_eq("rd_busy_ack", ack, 0);
    next_cycle();
    s_ack = '0;
    sample();
    check_eq("rd_ack", ack, 1);
    check_eq("rd_data", rdata, 32'hdeadbeef);
    check_eq("rd_err", err, 0);
    next_cycle();
    cyc = 0;
    sample();
    check_eq("rd_ack_pulse", ack, 0);
    check_eq("rd_data_hold", rdata, 32'hdeadbeef);

    // Write S1 with two stall cycles
    next_cycle();
    cyc = 1; stb = 1; we = 1; addr = 32'hb0008004; wdata = 32'h12345678; sel = 4'hf;
    s_stall = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      sample();
      check_eq("wr_stall_hi", stall, 1);
      check_eq("wr_sstb_stalled", s_stb, 4'b0010);
      next_cycle();
    end
    s_stall = '0;
    sample();
    check_eq("wr_stall_lo", stall, 0);
    check_eq("wr_sstb_last", s_stb, 4'b0010);
    check_eq("wr_sdata", s_wdata, 32'h12345678);
    check_eq("wr_swe", s_we, 1);
    check_eq("wr_ssel", s_sel, 4'hf);
    next_cycle();
    stb = 0; s_ack = 4'b0010;
    sample();
    check_eq("wr_busy_ack", ack, 0);
    check_eq("wr_busy_sstb", s_stb, 0);
    next_cycle();
    s_ack = '0;
    sample();
    check_eq("wr_ack", ack, 1);
    check_eq("wr_data_mux", rdata, 32'hcafef00d);
    next_cycle();
    cyc = 0; we = 0;
    sample();
    check_eq("wr_single_ack", ack, 0);

    // Unmapped access
    next_cycle();
    cyc = 1; stb = 1; addr = 32'ha0000000;
    sample();
    check_eq("miss_sstb", s_stb, 0);
    check_eq("miss_stall", stall, 0);
    check_eq("miss_err_early", err, 0);
    next_cycle();
    stb = 0;
    sample();
    check_eq("miss_err", err, 1);
    check_eq("miss_ack", ack, 0);
    check_eq("miss_stall_err", stall, 1);
`ifdef WBDEC_ERR_CAPTURE_EN
    check_eq("miss_cap_valid", err_valid, 1);
    check_eq("miss_cap_addr", err_addr, 32'ha0000000);
`endif
    next_cycle();
    sample();
    check_eq("miss_err_pulse", err, 0);
    next_cycle();
    cyc = 0;

    // Watchdog on S2
    next_cycle();
    cyc = 1; stb = 1; addr = 32'hc0000000;
    sample();
    check_eq("to_sstb", s_stb, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      stb = 0;
      sample();
      check_eq($sformatf("to_wait%0d_err", i), err, 0);
      check_eq($sformatf("to_wait%0d_scyc", i), s_cyc, 4'b0100);
    end
    next_cycle();
    sample();
    check_eq("to_err", err, 1);
    check_eq("to_ack", ack, 0);
`ifdef WBDEC_ERR_CAPTURE_EN
    check_eq("to_cap_sticky", err_addr, 32'ha0000000);
`endif
    next_cycle();
    s_ack = 4'b0100;
    sample();
    check_eq("to_err_pulse", err, 0);
    next_cycle();
    s_ack = '0;
    sample();
    check_eq("to_late_ack", ack, 0);
    next_cycle();
    cyc = 0;

    // Simultaneous ack and err from S1
    next_cycle();
    cyc = 1; stb = 1; addr = 32'hb0008000;
    next_cycle();
    stb = 0; s_ack = 4'b0010; s_err = 4'b0010;
    next_cycle();
    s_ack = '0; s_err = '0;
    sample();
    check_eq("ackerr_err", err, 1);
    check_eq("ackerr_ack", ack, 0);
    next_cycle();
    cyc = 0;

    // Reset while BUSY
    next_cycle();
    cyc = 1; stb = 1; addr = 32'hb0000000;
    next_cycle();
    stb = 0;
    sample();
    check_eq("rstb_busy_stall", stall, 1);
    next_cycle();
    reset = 1; cyc = 0;
    next_cycle();
    reset = 0;
    sample();
    check_eq("rstb_ack", ack, 0);
    check_eq("rstb_err", err, 0);
    check_eq("rstb_data", rdata, 0);
    check_eq("rstb_scyc", s_cyc, 0);
    check_eq("rstb_stall", stall, 0);

    // Master abort mid-BUSY
    next_cycle();
    cyc = 1; stb = 1; addr = 32'hc0000000;
    next_cycle();
    stb = 0;
    sample();
    check_eq("abort_busy_scyc", s_cyc, 4'b0100);
    next_cycle();
    cyc = 0; s_ack = 4'b0100;
    sample();
    check_eq("abort_scyc", s_cyc, 0);
    next_cycle();
    s_ack = '0;
    sample();
    check_eq("abort_ack", ack, 0);
    check_eq("abort_err", err, 0);
    next_cycle();
    cyc = 1; stb = 1; addr = 32'hb0000004;
    sample();
    check_eq("abort_idle_sstb", s_stb, 4'b0001);
    next_cycle();
    cyc = 0; stb = 0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_addr_decoder.md
Name: wb_addr_decoder

Overview:
Parametrised Wishbone (pipelined) 1-master to NSLAVES-slave address decoder and response router. Sits between the cpu core and its memories/peripherals, such as bootrom, internal RAM and IO. Replaces ad-hoc per-slave enable wiring with a table-driven address map. Adds registered response muxing, bus-error on unmapped addresses and a watchdog timeout.

Parameters:
NSLAVES, 4, number of slave ports (1..8).
AW, 32, address width.
DW, 32, data width (multiple of 8).
SLAVE_BASE, {NSLAVES{AW'h0}}, packed base addresses; slave i at bits [i*AW +: AW].
SLAVE_MASK, {NSLAVES{AW'h0}}, packed masks; slave i matches when (addr & MASK_i) == BASE_i.
TIMEOUT, 255, cycles in BUSY before forced error (1..65535).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
i_wb_cyc  in  1  master cycle.
i_wb_stb  in  1  master strobe.
i_wb_we  in  1  master write enable.
i_wb_addr  in  AW  master byte address.
i_wb_data  in  DW  master write data.
i_wb_sel  in  DW/8  byte selects.
o_wb_stall  out  1  stall to master.
o_wb_ack  out  1  ack to master.
o_wb_err  out  1  bus error to master.
o_wb_data  out  DW  read data to master.
o_s_cyc  out  NSLAVES  per-slave cyc.
o_s_stb  out  NSLAVES  per-slave stb.
o_s_we  out  1  broadcast we.
o_s_addr  out  AW  broadcast address.
o_s_data  out  DW  broadcast write data.
o_s_sel  out  DW/8  broadcast byte selects.
i_s_data  in  NSLAVES*DW  packed slave read data.
i_s_ack  in  NSLAVES  slave acks.
i_s_stall  in  NSLAVES  slave stalls.
i_s_err  in  NSLAVES  slave errors.

Behaviour:
- One clock domain; reset synchronous, active-high. On reset: state=IDLE; o_wb_ack, o_wb_err, o_s_cyc, o_s_stb = 0; o_wb_data = 0; timeout counter = 0.
- Decode (combinational): hit_i = (i_wb_addr & MASK_i) == BASE_i. If several hit, the lowest index wins. Miss = no hit.
- o_s_we/addr/data/sel are direct pass-through of the master signals.
- FSM IDLE / BUSY / ERR. One outstanding transaction only.
- IDLE:
  - o_s_stb[k] = i_wb_cyc & i_wb_stb & hit_k(winner).
  - o_s_cyc[k] = i_wb_cyc & hit_k(winner).
  - o_wb_stall = i_s_stall[winner] on hit; 0 on miss.
  - Accept = cyc & stb & !o_wb_stall. On accept with hit: latch sel=k, go to BUSY, clear counter.
  - On accept with miss: go to ERR.
- BUSY:
  - o_s_cyc[sel] = 1 while i_wb_cyc; all o_s_stb = 0; o_wb_stall = 1.
  - On i_s_ack[sel]: register o_wb_data = slave data and pulse o_wb_ack for one cycle on the next edge; return to IDLE.
  - On i_s_err[sel]: pulse o_wb_err for one cycle instead; return to IDLE. If ack and err arrive together, err wins.
  - Counter increments each BUSY cycle. When counter == TIMEOUT-1 with no response, pulse o_wb_err and return to IDLE.
  - Late acks from a timed-out slave are ignored.
- ERR: o_wb_stall = 1; pulse o_wb_err for one cycle; return to IDLE next cycle.
- Latency: slave ack at cycle t gives o_wb_ack at t+1. Unmapped access accepted at t gives o_wb_err at t+1.
- Master drops i_wb_cyc in BUSY/ERR: abort to IDLE next edge, no ack/err emitted, o_s_cyc all 0 that same cycle.
- o_wb_data holds its last value when no ack is issued.
- o_wb_ack and o_wb_err are never simultaneously 1. At most one bit of o_s_cyc is 1.

Optional Feature:
WBDEC_ERR_CAPTURE_EN:
- Defined: adds outputs o_err_addr (AW) and o_err_valid (1), plus input i_err_clr (1).
- On any o_wb_err pulse (miss, slave err or timeout) with o_err_valid=0: latch the faulting address and set o_err_valid. The first error is sticky until i_err_clr=1 or reset.
- If i_err_clr and a new error coincide, the new error is captured.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Map S0 0xb0000000/0xffff8000, S1 0xb0008000/0xffff8000, S2 0xc0000000/0xfffff000. Read 0xb0000010, S0 acks with 0xdeadbeef one cycle after stb -> o_s_stb=0001 for one cycle, o_wb_ack one cycle after S0 ack, o_wb_data=0xdeadbeef.
- Write 0xb0008004 data 0x12345678 sel=1111, S1 stalls 2 cycles -> o_wb_stall mirrors the stall, o_s_stb[1] held 3 cycles, single ack after S1 acks.
- Access 0xa0000000 -> no o_s_stb, o_wb_err pulses one cycle after accept, o_wb_ack stays 0; with WBDEC_ERR_CAPTURE_EN, o_err_addr=0xa0000000 and o_err_valid=1.
- TIMEOUT=8, S2 never acks on access to 0xc0000000 -> o_wb_err after 8 BUSY cycles; a later S2 ack produces no o_wb_ack.
- S1 asserts i_s_ack and i_s_err in the same cycle -> o_wb_err=1, o_wb_ack=0.
- Assert reset while in BUSY -> next cycle all outputs 0 and state IDLE; drop i_wb_cyc mid-BUSY -> no ack/err, o_s_cyc=0000.
